// File: rtl/mux_pkg.sv
// Shared definitions for the channel multiplexer / scanner.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_next_chan.sv
// Cyclic search for the first enabled channel at or after ptr; also flags
// whether that channel is the highest-index enabled one.
module mux_next_chan #(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] en_mask,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    chan,
  output logic                found,
  output logic                is_last
);

  logic [SEL_W-1:0] hi_c;

  always_comb begin
    chan    = '0;
    found   = 1'b0;
    is_last = 1'b0;
    hi_c    = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (en_mask[SEL_W'(k)]) hi_c = SEL_W'(k);
    end
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      int unsigned idx;
      idx = 32'(ptr) + (i - 1);
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (en_mask[SEL_W'(idx)]) begin
        chan  = SEL_W'(idx);
        found = 1'b1;
      end
    end
    is_last = found && (chan == hi_c);
  end

endmodule

// File: rtl/mux_scanner.sv
// Registered channel multiplexer with manual select and round-robin auto-scan
// over enabled channels, behind a valid/ready output stage.
module mux_scanner
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       en_mask,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_last
);

  localparam int unsigned OFF_W = $clog2(CHANNELS * WIDTH);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] nc_chan;
  logic             nc_found;
  logic             nc_last;
  logic             load_c;

  mux_next_chan #(.CHANNELS(CHANNELS)) u_next_chan (
    .en_mask (en_mask),
    .ptr     (ptr),
    .chan    (nc_chan),
    .found   (nc_found),
    .is_last (nc_last)
  );

  assign load_c = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      ptr       <= '0;
    end else if (load_c) begin
      if (mode == MODE_SCAN) begin
        // Empty mask: drop valid but keep the last sample and scan position.
        if (nc_found) begin
          out_data  <= data_in[OFF_W'(nc_chan) * OFF_W'(WIDTH) +: WIDTH];
          out_chan  <= nc_chan;
          out_valid <= 1'b1;
          out_last  <= nc_last;
          ptr       <= (32'(nc_chan) == CHANNELS - 1) ? '0 : nc_chan + SEL_W'(1);
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else begin
        out_last <= 1'b0;
        if (32'(sel) < CHANNELS) begin
          out_data  <= data_in[OFF_W'(sel) * OFF_W'(WIDTH) +: WIDTH];
          out_chan  <= sel;
          out_valid <= en_mask[sel];
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scanner.sv
// Self-checking bench for mux_scanner: directed scenarios plus randomized
// traffic against a behavioural model of the select/scan rules.
module tb_mux_scanner;

  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk;
  logic          rst;
  logic [CH*W-1:0] data_in;
  logic [1:0]    sel;
  logic          mode;
  logic [CH-1:0] en_mask;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_chan;
  logic          out_last;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  bit         m_last;
  int         m_ptr;

  mux_scanner #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .sel       (sel),
    .mode      (mode),
    .en_mask   (en_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the select/scan rules to the inputs present at the coming edge.
  task automatic model_step();
    int c;
    int hi;
    if (rst) begin
      m_valid = 0; m_data = 8'h00; m_chan = 0; m_last = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (mode == 1'b0) begin
        m_last = 0;
        if (int'(sel) >= CH) m_valid = 0;
        else begin
          m_data  = data_in[int'(sel)*W +: W];
          m_chan  = int'(sel);
          m_valid = en_mask[sel];
        end
      end else if (en_mask == '0) begin
        m_valid = 0; m_last = 0;
      end else begin
        c = -1; hi = -1;
        for (int o = 0; o < CH; o++)
          if (c < 0 && en_mask[(m_ptr + o) % CH]) c = (m_ptr + o) % CH;
        for (int k = 0; k < CH; k++) if (en_mask[k]) hi = k;
        m_data  = data_in[c*W +: W];
        m_chan  = c;
        m_valid = 1;
        m_last  = (c == hi);
        m_ptr   = (c + 1) % CH;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1; sel = 0; mode = 0; en_mask = 4'hF; out_ready = 1;
    tick();
    checks++;
    if ({out_valid, out_data, out_chan, out_last} !== 12'h000) begin
      failures++;
      $display("FAIL reset got=%h expected=000", {out_valid, out_data, out_chan, out_last});
    end
    rst = 0;
  endtask

  task automatic test_manual();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    mode = 0; en_mask = 4'hF; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      checks++;
      if ({out_valid, out_data, out_chan, out_last} !== {1'b1, exp_d[i], 2'(i), 1'b0}) begin
        failures++;
        $display("FAIL manual_sel%0d got v=%b d=%h c=%0d l=%b expected v=1 d=%h c=%0d l=0",
                 i, out_valid, out_data, out_chan, out_last, exp_d[i], i);
      end
    end
  endtask

  task automatic test_scan();
    int exp_c [6] = '{0, 1, 3, 0, 1, 3};
    logic [7:0] ch_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    mode = 1; en_mask = 4'b1011; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({out_valid, out_data, out_chan, out_last} !==
          {1'b1, ch_d[exp_c[i]], 2'(exp_c[i]), exp_c[i] == 3}) begin
        failures++;
        $display("FAIL scan_step%0d got v=%b d=%h c=%0d l=%b expected chan %0d",
                 i, out_valid, out_data, out_chan, out_last, exp_c[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    rst = 1; tick(); rst = 0;
    mode = 1; en_mask = 4'hF; out_ready = 1;
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, out_data, out_chan} !== {1'b1, 8'h11, 2'd0}) begin
        failures++;
        $display("FAIL hold%0d got v=%b d=%h c=%0d expected v=1 d=11 c=0",
                 i, out_valid, out_data, out_chan);
      end
    end
    out_ready = 1;
    tick();
    checks++;
    if ({out_valid, out_data, out_chan} !== {1'b1, 8'h22, 2'd1}) begin
      failures++;
      $display("FAIL release got v=%b d=%h c=%0d expected v=1 d=22 c=1",
               out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_disabled();
    // Scan position is 2 here (last scan sample was channel 1).
    mode = 0; sel = 2; en_mask = 4'b1011; out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL manual_disabled got valid=%b expected 0", out_valid);
    end
    mode = 1; en_mask = 4'b0000;
    tick();
    checks++;
    if ({out_valid, out_last} !== 2'b00) begin
      failures++;
      $display("FAIL scan_empty got v=%b l=%b expected 0 0", out_valid, out_last);
    end
    en_mask = 4'hF;
    tick();
    checks++;
    if ({out_valid, out_chan} !== {1'b1, 2'd2}) begin
      failures++;
      $display("FAIL ptr_kept got v=%b c=%0d expected v=1 c=2", out_valid, out_chan);
    end
  endtask

  task automatic test_single();
    mode = 1; en_mask = 4'b0100; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, out_data, out_chan, out_last} !== {1'b1, 8'h33, 2'd2, 1'b1}) begin
        failures++;
        $display("FAIL single%0d got v=%b d=%h c=%0d l=%b expected v=1 d=33 c=2 l=1",
                 i, out_valid, out_data, out_chan, out_last);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 1; en_mask = 4'hF; out_ready = 1;
    tick(); tick();
    out_ready = 0;
    tick();
    rst = 1;
    tick();
    checks++;
    if ({out_valid, out_data, out_chan, out_last} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid got v=%b d=%h c=%0d l=%b expected all 0",
               out_valid, out_data, out_chan, out_last);
    end
    rst = 0; out_ready = 1;
    tick();
    checks++;
    if ({out_valid, out_data, out_chan} !== {1'b1, 8'h11, 2'd0}) begin
      failures++;
      $display("FAIL after_reset got v=%b d=%h c=%0d expected v=1 d=11 c=0",
               out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      data_in   = $urandom;
      sel       = 2'($urandom_range(0, 3));
      mode      = 1'($urandom_range(0, 2) != 0);
      en_mask   = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      checks++;
      if ({out_valid, out_data, out_chan, out_last} !==
          {m_valid, m_data, 2'(m_chan), m_last}) begin
        failures++;
        $display("FAIL random%0d got v=%b d=%h c=%0d l=%b expected v=%b d=%h c=%0d l=%b",
                 i, out_valid, out_data, out_chan, out_last, m_valid, m_data, m_chan, m_last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_disabled();
    test_single();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of input channels (legal range 2..16).
REQ-003 SHALL have derived localparam SEL_W = clog2(CHANNELS), meaning channel-index width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port data_in  input  CHANNELS*WIDTH  meaning packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  SEL_W  meaning channel index used in manual mode.
REQ-008 SHALL have port mode  input  1  meaning 0 = manual select, 1 = auto-scan.
REQ-009 SHALL have port en_mask  input  CHANNELS  meaning a 1 in bit k enables channel k.
REQ-010 SHALL have port out_ready  input  1  meaning the downstream accepts out_data this cycle.
REQ-011 SHALL have port out_valid  output  1  meaning out_data/out_chan/out_last hold a valid sample.
REQ-012 SHALL have port out_data  output  WIDTH  meaning the registered selected channel data.
REQ-013 SHALL have port out_chan  output  SEL_W  meaning the index of the channel in out_data.
REQ-014 SHALL have port out_last  output  1  meaning the sample is the last enabled channel of a scan frame.

Function
REQ-015 SHALL perform a "load" on every edge where (!out_valid || out_ready) and rst = 0; there SHALL be no other output update.
REQ-016 SHALL hold out_valid, out_data, out_chan and out_last stable while out_valid = 1 and out_ready = 0.
REQ-017 SHALL have a latency of exactly one cycle from data_in sampled at a load to out_data.
REQ-018 In manual mode, a load SHALL capture data_in[sel], set out_chan = sel, out_last = 0 and out_valid = en_mask[sel].
REQ-019 In manual mode, a load with sel >= CHANNELS SHALL set out_valid = 0 and leave out_data and out_chan unchanged.
REQ-020 SHALL keep an internal scan pointer ptr (SEL_W bits) that changes only on scan-mode loads and on reset.
REQ-021 In scan mode, a load SHALL select c = the first enabled channel at or after ptr, searching cyclically (ptr, ptr+1, ..., CHANNELS-1, 0, ...).
REQ-022 In scan mode, a load SHALL capture data_in[c], set out_chan = c and out_valid = 1, and set ptr = (c+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
REQ-023 In scan mode, out_last SHALL be 1 iff c is the highest-index enabled channel.
REQ-024 In scan mode with en_mask = 0, a load SHALL set out_valid = 0 and out_last = 0, and SHALL leave ptr, out_data and out_chan unchanged.
REQ-025 A change of mode or en_mask SHALL take effect at the next load, with no flush; ptr SHALL retain its value across mode changes.
REQ-026 A single enabled channel in scan mode SHALL be re-selected on every load, with out_last = 1 each time.

Reset
REQ-027 When rst = 1 at a rising edge, the block SHALL set out_valid = 0, out_data = 0, out_chan = 0, out_last = 0 and ptr = 0, regardless of out_ready or an in-flight sample.
REQ-028 Reset SHALL have priority over any load in the same cycle; the first load SHALL occur on the first edge with rst = 0.

Structure
REQ-029 Mode encodings (MODE_MANUAL = 0, MODE_SCAN = 1) SHALL reside in the shared package mux_pkg.
REQ-030 The cyclic next-enabled-channel search SHALL be a combinational sub-module mux_next_chan, parametrised by CHANNELS, with inputs (en_mask, ptr) and outputs (chan, found, is_last).
REQ-031 All state SHALL be in a single clocked process; the WIDTH-bit channel selection SHALL be an indexed part-select.

Verification (WIDTH=8, CHANNELS=4, data_in ch0..ch3 = 0x11, 0x22, 0x33, 0x44)
REQ-032 Bench: manual, en_mask=4'hF, out_ready=1, sel=0,1,2,3 on successive cycles -> out_data 0x11, 0x22, 0x33, 0x44 one cycle later, out_chan 0..3, out_valid=1.
REQ-033 Bench: scan, en_mask=4'b1011, out_ready=1 for 6 cycles -> out_chan 0,1,3,0,1,3; out_last=1 only with chan 3; out_data 0x11, 0x22, 0x44, ...
REQ-034 Bench: scan, out_ready=0 for 3 cycles after the first valid -> out_chan and out_data frozen at 0/0x11; on out_ready=1 the next sample is chan 1.
REQ-035 Bench: manual, sel=2 with en_mask=4'b1011 -> out_valid=0; then scan with en_mask=0 -> out_valid stays 0 and ptr is unchanged.
REQ-036 Bench: rst=1 asserted mid-scan while out_valid=1 and out_ready=0 -> next edge out_valid=0, out_data=0, out_chan=0; after release the first scan sample is chan 0.
